// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, sequencer states and slice-op mapping.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // SLT is run through the slice as ADD so that the MSB sum bit is available.
    function automatic logic [1:0] slice_op(input logic [1:0] op);
        return (op == 2'b11) ? 2'b10 : op;
    endfunction

endpackage

// File: rtl/bit_alu.sv
// One-bit ALU slice: AND/OR/ADD/LESS with optional operand inversion.
module bit_alu (
    input  logic       a,
    input  logic       b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       carry_in,
    input  logic       less,
    input  logic [1:0] operation,
    output logic       result,
    output logic       carry_out
);

    logic w_a;
    logic w_b;
    logic w_sum;

    always_comb begin
        w_a       = a ^ a_invert;
        w_b       = b ^ b_invert;
        w_sum     = w_a ^ w_b ^ carry_in;
        carry_out = (w_a & w_b) | (carry_in & (w_a ^ w_b));
        unique case (operation)
            2'b00:   result = w_a & w_b;
            2'b01:   result = w_a | w_b;
            2'b10:   result = w_sum;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one bit_alu slice stepped LSB first, with valid/ready on both sides.
module serial_alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  r_res_sh;
    logic [WIDTH-1:0]  r_result;
    logic [3:0]        r_ctrl;
    logic              r_c;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_zero;
    logic              r_ovf;

    logic              w_slice_res;
    logic              w_slice_cout;
    logic              w_accept;
    logic              w_last;
    logic              w_ov;
    logic [WIDTH-1:0]  w_word;
    logic [WIDTH-1:0]  w_final;

    bit_alu u_bit_alu (
        .a         (r_a_sh[0]),
        .b         (r_b_sh[0]),
        .a_invert  (r_ctrl[3]),
        .b_invert  (r_ctrl[2]),
        .carry_in  (r_c),
        .less      (1'b0),
        .operation (slice_op(r_ctrl[1:0])),
        .result    (w_slice_res),
        .carry_out (w_slice_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Final word is formed from the live MSB slice outputs on the edge entering DONE.
    always_comb begin
        w_accept = (r_state == ST_IDLE) && in_valid;
        w_last   = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
        w_ov     = r_c ^ w_slice_cout;
        w_word   = {w_slice_res, r_res_sh[WIDTH-1:1]};
        if (r_ctrl[1:0] == 2'b11) w_final = {{(WIDTH-1){1'b0}}, w_slice_res ^ w_ov};
        else                      w_final = w_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_result <= '0;
            r_ctrl   <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_res_sh <= '0;
            r_ctrl   <= alu_ctrl;
            r_c      <= alu_ctrl[2];
            r_cnt    <= '0;
        end else if (r_state == ST_RUN) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_res_sh <= w_word;
            r_c      <= w_slice_cout;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_final;
                r_zero   <= (w_final == '0);
                r_ovf    <= (r_ctrl[1:0] == 2'b10) ? w_ov : 1'b0;
            end
        end
    end

    assign result   = r_result;
    assign zero     = r_zero;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq: directed table, handshake/reset corners, random ops.
module tb_serial_alu_seq;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic [3:0]   alu_ctrl  = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   c;
        logic [W-1:0] r;
        logic         z;
        logic         ov;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic on the (optionally inverted) operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [3:0] mc,
                         output logic [W-1:0] r, output logic z, output logic ov);
        logic [W-1:0] ai;
        logic [W-1:0] bi;
        logic [W:0]   s;
        logic         v;
        ai = mc[3] ? ~ma : ma;
        bi = mc[2] ? ~mb : mb;
        s  = {1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, mc[2]};
        v  = (ai[W-1] == bi[W-1]) && (s[W-1] != ai[W-1]);
        case (mc[1:0])
            2'b00:   r = ai & bi;
            2'b01:   r = ai | bi;
            2'b10:   r = s[W-1:0];
            default: r = {{(W-1){1'b0}}, s[W-1] ^ v};
        endcase
        z  = (r == '0);
        ov = (mc[1:0] == 2'b10) ? v : 1'b0;
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] tc);
        @(negedge clk);
        a        = ta;
        b        = tb_;
        alu_ctrl = tc;
        in_valid = 1'b1;
        check("in_ready_at_issue", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        alu_ctrl = 4'($urandom_range(0, 15));
    endtask

    // Counts edges after the accept edge until out_valid; optionally pokes junk ops mid-RUN.
    task automatic wait_done(input bit junk);
        int lat;
        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            if (junk && lat == 2) begin
                a        = 32'hDEAD_BEEF;
                b        = 32'h1234_5678;
                alu_ctrl = 4'b0010;
                in_valid = 1'b1;
            end
            if (junk && lat == 5) in_valid = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, W);
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_retire", out_valid, 0);
        check("in_ready_after_retire", in_ready, 1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [3:0] tc, input int hold);
        logic [W-1:0] er;
        logic         ez;
        logic         eov;
        model(ta, tb_, tc, er, ez, eov);
        issue(ta, tb_, tc);
        wait_done(1'b0);
        repeat (hold) @(posedge clk);
        #1;
        check({name, "_result"}, result, er);
        check({name, "_zero"}, zero, ez);
        check({name, "_overflow"}, overflow, eov);
        retire();
    endtask

    initial begin
        logic [W-1:0] held;

        vt[0]  = '{32'd7,         32'd5,         4'b0010, 32'd12,        1'b0, 1'b0};
        vt[1]  = '{32'd5,         32'd5,         4'b0110, 32'd0,         1'b1, 1'b0};
        vt[2]  = '{32'h7FFF_FFFF, 32'd1,         4'b0010, 32'h8000_0000, 1'b0, 1'b1};
        vt[3]  = '{32'h7FFF_FFFF, 32'd1,         4'b0001, 32'h7FFF_FFFF, 1'b0, 1'b0};
        vt[4]  = '{32'hFFFF_FFFD, 32'd2,         4'b0111, 32'd1,         1'b0, 1'b0};
        vt[5]  = '{32'h8000_0000, 32'd1,         4'b0111, 32'd1,         1'b0, 1'b0};
        vt[6]  = '{32'd5,         32'd3,         4'b0111, 32'd0,         1'b1, 1'b0};
        vt[7]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 32'hF000_F000, 1'b0, 1'b0};
        vt[8]  = '{32'd0,         32'd0,         4'b1100, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vt[9]  = '{32'd3,         32'd5,         4'b0110, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[10] = '{32'h8000_0000, 32'd1,         4'b0110, 32'h7FFF_FFFF, 1'b0, 1'b1};

        // Reset state, with an op offered while reset is held.
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_overflow", overflow, 0);
        a        = 32'd9;
        b        = 32'd9;
        alu_ctrl = 4'b0010;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;
        check("no_op_from_reset_out_valid", out_valid, 0);
        check("no_op_from_reset_in_ready", in_ready, 1);

        for (int i = 0; i < 11; i++) begin
            issue(vt[i].a, vt[i].b, vt[i].c);
            wait_done(1'b0);
            check($sformatf("vec%0d_result", i), result, vt[i].r);
            check($sformatf("vec%0d_zero", i), zero, vt[i].z);
            check($sformatf("vec%0d_overflow", i), overflow, vt[i].ov);
            retire();
        end

        // NOR with junk in_valid during RUN and 5 cycles of backpressure.
        issue(32'd0, 32'd0, 4'b1100);
        wait_done(1'b1);
        check("bp_result", result, 32'hFFFF_FFFF);
        check("bp_in_ready_done", in_ready, 0);
        held = result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid_hold", out_valid, 1);
            check("bp_result_hold", result, held);
        end
        // Retire while a new op is offered: the offer must not be taken.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 32'd1;
        b         = 32'd1;
        alu_ctrl  = 4'b0010;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_in_ready_after_retire", in_ready, 1);
        check("bp_out_valid_after_retire", out_valid, 0);
        repeat (W + 3) @(posedge clk);
        #1;
        check("no_accept_on_retire_edge", out_valid, 0);

        // Asynchronous reset at cnt==10.
        issue(32'h1234_5678, 32'd1, 4'b0010);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(posedge clk);
        #1;
        check("midrun_rst_no_result", out_valid, 0);
        run_op("post_rst_add", 32'd1, 32'd1, 4'b0010, 0);

        // Reset while holding a result in DONE.
        issue(32'd4, 32'd4, 4'b0010);
        wait_done(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("done_rst_out_valid", out_valid, 0);
        check("done_rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = (i % 4 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            rb = (i % 4 == 0) ? ra : W'($urandom);
            if (i % 7 == 0) ra = {1'b1, ra[W-2:0]};
            run_op($sformatf("rand%0d", i), ra, rb, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
